// File: rtl/fused_ofm_writeback.sv
// fused_ofm_writeback: packs layer-2 bytes into 128-bit words and writes them to global BRAM via a small FIFO; OFM_WSTRB_EN adds per-lane write strobes
module fused_ofm_writeback #(
  parameter int DATA_W     = 8,
  parameter int LANES      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [31:0]             base_addr_OFM,
  input  logic [31:0]             size_OFM,
  input  logic                    valid_layer2,
  input  logic [DATA_W-1:0]       data_layer2,
  output logic                    in_ready,
  output logic [31:0]             wr_addr_global,
  output logic [DATA_W*LANES-1:0] wr_data_global,
  output logic                    we_global,
  input  logic                    global_wr_ready,
  output logic                    done_compute,
  output logic                    busy
`ifdef OFM_WSTRB_EN
  ,
  output logic [LANES-1:0]        wr_strb_global
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(LANES);
  typedef enum logic [2:0] {IDLE, PACK, FLUSH, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [31:0] base, size, byte_cnt, word_cnt;
  logic [LW-1:0] lane_idx;
  logic [LANES-1:0][DATA_W-1:0] lanes, word_n;
  logic [LANES-1:0][DATA_W-1:0] fdata [FIFO_DEPTH];
  logic [31:0] faddr [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic fifo_empty, fifo_full, accept, last, full_lane, push, pop;
  assign fifo_empty = wp == rp;
  assign fifo_full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign in_ready = (state == PACK) && !fifo_full;
  assign accept = valid_layer2 && in_ready;
  assign last = byte_cnt == size - 32'd1;
  assign full_lane = lane_idx == LW'(LANES-1);
  assign push = (accept && full_lane) || (state == FLUSH && !fifo_full);
  assign pop = we_global && global_wr_ready;
  assign we_global = !fifo_empty;
  assign wr_addr_global = faddr[rp[AW-1:0]];
  assign wr_data_global = fdata[rp[AW-1:0]];
  assign done_compute = state == DONE;
  assign busy = state != IDLE;
  // in FLUSH, lanes at and above lane_idx were never filled for this job
  always_comb begin
    for (int i = 0; i < LANES; i++)
      word_n[i] = (state == FLUSH && i >= int'(lane_idx)) ? '0 :
                  (i == int'(lane_idx)) ? data_layer2 : lanes[i];
  end
`ifdef OFM_WSTRB_EN
  logic [LANES-1:0] strb_n;
  logic [LANES-1:0] fstrb [FIFO_DEPTH];
  assign wr_strb_global = fstrb[rp[AW-1:0]];
  always_comb begin
    for (int i = 0; i < LANES; i++)
      strb_n[i] = (state != FLUSH) || (i < int'(lane_idx));
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      for (int i = 0; i < FIFO_DEPTH; i++) fstrb[i] <= '0;
    else if (push)
      fstrb[wp[AW-1:0]] <= strb_n;
  end
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (size_OFM == 32'd0) ? DONE : PACK;
      PACK:    if (accept && last) state_n = full_lane ? DRAIN : FLUSH;
      FLUSH:   if (!fifo_full) state_n = DRAIN;
      DRAIN:   if (fifo_empty) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      base <= '0;
      size <= '0;
      byte_cnt <= '0;
      word_cnt <= '0;
      lane_idx <= '0;
      lanes <= '0;
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fdata[i] <= '0;
        faddr[i] <= '0;
      end
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        base <= base_addr_OFM;
        size <= size_OFM;
        byte_cnt <= '0;
        word_cnt <= '0;
        lane_idx <= '0;
      end
      if (accept) begin
        lanes[lane_idx] <= data_layer2;
        byte_cnt <= byte_cnt + 32'd1;
        lane_idx <= full_lane ? '0 : lane_idx + 1'b1;
      end
      if (push) begin
        fdata[wp[AW-1:0]] <= word_n;
        faddr[wp[AW-1:0]] <= base + (word_cnt << 4);
        word_cnt <= word_cnt + 32'd1;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
  end
endmodule

// File: tb/tb_fused_ofm_writeback.sv
// tb_fused_ofm_writeback: directed table-driven bench for fused_ofm_writeback
module tb_fused_ofm_writeback;
  logic clk = 0, reset_n = 0, start = 0, valid_layer2 = 0, global_wr_ready = 1;
  logic [31:0] base_addr_OFM = 0, size_OFM = 0;
  logic [7:0] data_layer2 = 0;
  logic in_ready, we_global, done_compute, busy;
  logic [31:0] wr_addr_global;
  logic [127:0] wr_data_global;
`ifdef OFM_WSTRB_EN
  logic [15:0] wr_strb_global;
`endif

  always #5 clk = ~clk;

  fused_ofm_writeback dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .base_addr_OFM(base_addr_OFM), .size_OFM(size_OFM),
    .valid_layer2(valid_layer2), .data_layer2(data_layer2), .in_ready(in_ready),
    .wr_addr_global(wr_addr_global), .wr_data_global(wr_data_global),
    .we_global(we_global), .global_wr_ready(global_wr_ready),
    .done_compute(done_compute), .busy(busy)
`ifdef OFM_WSTRB_EN
    , .wr_strb_global(wr_strb_global)
`endif
  );

  typedef struct {
    int job;
    logic [31:0] addr;
    logic [127:0] data;
    logic [15:0] strb;
  } wr_t;
  wr_t exp_tbl[14];

  int checks = 0, errors = 0, cyc = 0, sent = 0, to_send = 0;
  int done_cnt = 0, done_cyc = 0, last_wr_cyc = 0, start_cyc = 0, d0 = 0;
  logic [7:0] seed = 0;
  logic feed_acc;
  logic [31:0] q_addr[$];
  logic [127:0] q_data[$];
  logic [15:0] q_strb[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  initial forever begin
    @(negedge clk);
    feed_acc = valid_layer2 && in_ready;
    @(posedge clk);
    #1;
    if (feed_acc) sent++;
    valid_layer2 = sent < to_send;
    data_layer2 = seed + 8'(sent);
  end

  initial forever begin
    @(negedge clk);
    if (we_global && global_wr_ready) begin
      q_addr.push_back(wr_addr_global);
      q_data.push_back(wr_data_global);
`ifdef OFM_WSTRB_EN
      q_strb.push_back(wr_strb_global);
`else
      q_strb.push_back(16'hFFFF);
`endif
      last_wr_cyc = cyc;
    end
    if (done_compute) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic start_job(input logic [31:0] b, input logic [31:0] s, input logic [7:0] sd);
    @(posedge clk); #2;
    q_addr.delete(); q_data.delete(); q_strb.delete();
    sent = 0; to_send = int'(s); seed = sd;
    base_addr_OFM = b; size_OFM = s; start = 1; start_cyc = cyc;
    @(posedge clk); #2;
    start = 0;
  endtask

  task automatic wait_done(input int lim, input string tag, input int base_cnt);
    for (int i = 0; i < lim && done_cnt == base_cnt; i++) @(posedge clk);
    chk({tag, "_done_seen"}, done_cnt > base_cnt, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic compare_job(input int j, input string tag);
    int n = 0;
    for (int k = 0; k < 14; k++) begin
      if (exp_tbl[k].job == j) begin
        if (n < q_addr.size()) begin
          chk($sformatf("%s_addr%0d", tag, n), q_addr[n], exp_tbl[k].addr);
          chk($sformatf("%s_data%0d", tag, n), q_data[n], exp_tbl[k].data);
`ifdef OFM_WSTRB_EN
          chk($sformatf("%s_strb%0d", tag, n), q_strb[n], exp_tbl[k].strb);
`endif
        end
        n++;
      end
    end
    chk({tag, "_nwrites"}, q_addr.size(), n);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_we"}, we_global, 0);
    chk({tag, "_addr"}, wr_addr_global, 0);
    chk({tag, "_data"}, wr_data_global, 0);
    chk({tag, "_done"}, done_compute, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    exp_tbl[0]  = '{0, 32'h100,  128'h0F0E0D0C0B0A09080706050403020100, 16'hFFFF};
    exp_tbl[1]  = '{0, 32'h110,  128'h1F1E1D1C1B1A19181716151413121110, 16'hFFFF};
    exp_tbl[2]  = '{1, 32'h200,  128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, 16'hFFFF};
    exp_tbl[3]  = '{1, 32'h210,  128'hB4B3B2B1B0,                       16'h001F};
    exp_tbl[4]  = '{2, 32'h1000, 128'h0F0E0D0C0B0A09080706050403020100, 16'hFFFF};
    exp_tbl[5]  = '{2, 32'h1010, 128'h1F1E1D1C1B1A19181716151413121110, 16'hFFFF};
    exp_tbl[6]  = '{2, 32'h1020, 128'h2F2E2D2C2B2A29282726252423222120, 16'hFFFF};
    exp_tbl[7]  = '{2, 32'h1030, 128'h3F3E3D3C3B3A39383736353433323130, 16'hFFFF};
    exp_tbl[8]  = '{2, 32'h1040, 128'h4F4E4D4C4B4A49484746454443424140, 16'hFFFF};
    exp_tbl[9]  = '{2, 32'h1050, 128'h5F5E5D5C5B5A59585756555453525150, 16'hFFFF};
    exp_tbl[10] = '{3, 32'h2000, 128'h4F4E4D4C4B4A49484746454443424140, 16'hFFFF};
    exp_tbl[11] = '{3, 32'h2010, 128'h5F5E5D5C5B5A59585756555453525150, 16'hFFFF};
    exp_tbl[12] = '{3, 32'h2020, 128'h6F6E6D6C6B6A69686766656463626160, 16'hFFFF};
    exp_tbl[13] = '{3, 32'h2030, 128'h7F7E7D7C7B7A79787776757473727170, 16'hFFFF};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("rst");
    @(posedge clk); #2;
    reset_n = 1;

    d0 = done_cnt;
    start_job(32'h100, 32, 8'h00);
    repeat (5) @(posedge clk);
    #2;
    base_addr_OFM = 32'h900; size_OFM = 0; start = 1;
    @(posedge clk); #2;
    start = 0;
    wait_done(400, "j0", d0);
    chk("j0_busy_after", busy, 0);
    chk("j0_done_count", done_cnt - d0, 1);
    chk("j0_done_latency", done_cyc, last_wr_cyc + 2);
    compare_job(0, "j0");

    d0 = done_cnt;
    start_job(32'h200, 21, 8'hA0);
    wait_done(400, "j1", d0);
    chk("j1_done_count", done_cnt - d0, 1);
    chk("j1_done_latency", done_cyc, last_wr_cyc + 2);
    compare_job(1, "j1");

    d0 = done_cnt;
    global_wr_ready = 0;
    start_job(32'h1000, 96, 8'h00);
    repeat (120) @(posedge clk);
    @(negedge clk);
    chk("bp_bytes_taken", sent, 64);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_we", we_global, 1);
    chk("bp_busy", busy, 1);
    chk("bp_head_addr", wr_addr_global, 32'h1000);
    chk("bp_head_data", wr_data_global, 128'h0F0E0D0C0B0A09080706050403020100);
    @(posedge clk); #2;
    global_wr_ready = 1;
    wait_done(400, "j2", d0);
    chk("j2_done_count", done_cnt - d0, 1);
    compare_job(2, "j2");

    start_job(32'h0, 64, 8'h00);
    for (int i = 0; i < 200 && sent < 20; i++) begin
      @(posedge clk); #2;
    end
    chk("rs_bytes_before_reset", sent, 20);
    reset_n = 0;
    to_send = 0;
    @(negedge clk);
    chk_idle_outputs("rs");
    @(posedge clk); #2;
    reset_n = 1;
    d0 = done_cnt;
    start_job(32'h2000, 64, 8'h40);
    wait_done(400, "j3", d0);
    chk("j3_done_count", done_cnt - d0, 1);
    compare_job(3, "j3");

    d0 = done_cnt;
    start_job(32'h3000, 0, 8'h00);
    start = 1;
    @(posedge clk); #2;
    start = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("z_done_count", done_cnt - d0, 1);
    chk("z_done_cycle", done_cyc, start_cyc + 1);
    chk("z_no_writes", q_addr.size(), 0);
    chk("z_busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
